// File: rtl/aes_spi_ctrl_pkg.sv
// Shared types and constants for the SPI-driven AES sequencer.
package aes_pkg;

  localparam int KEY_W = 128;
  localparam int BLK_W = 128;

  // Bit positions inside the published status byte
  localparam int STAT_VALID   = 0;
  localparam int STAT_TIMEOUT = 1;
  localparam int STAT_OVERRUN = 2;
  localparam int STAT_BUSY    = 3;
  localparam int STAT_SEQ_LSB = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    START  = 2'd2,
    RUN    = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic [3:0] seq;
    logic       busy;
    logic       overrun;
    logic       timeout;
    logic       valid;
  } status_t;

endpackage

// File: rtl/aes_spi_ctrl_if.sv
// Controller <-> AES core handshake. The controller is the master.
interface aes_spi_ctrl_if #(
  parameter int KEY_W = aes_pkg::KEY_W,
  parameter int BLK_W = aes_pkg::BLK_W
);

  logic             core_start;
  logic [KEY_W-1:0] core_key;
  logic [BLK_W-1:0] core_pt;
  logic             core_done;
  logic [BLK_W-1:0] core_ct;

  modport master (
    output core_start,
    output core_key,
    output core_pt,
    input  core_done,
    input  core_ct
  );

  modport slave (
    input  core_start,
    input  core_key,
    input  core_pt,
    output core_done,
    output core_ct
  );

endinterface

// File: rtl/aes_spi_ctrl.sv
// Sequences one AES encryption per SPI transaction and publishes
// ciphertext plus status on full_miso for the next transaction.
//
// state  | meaning
// IDLE   | waiting for end of an SPI transaction (spi_done rise)
// SETTLE | one cycle for full_mosi to settle; key/pt latched on exit
// START  | core_start pulse, timer cleared
// RUN    | waiting for core_done or timeout
module aes_spi_ctrl #(
  parameter int KEY_W   = aes_pkg::KEY_W,
  parameter int BLK_W   = aes_pkg::BLK_W,
  parameter int N       = KEY_W + BLK_W,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           spi_done,
  input  logic [N-1:0]   full_mosi,
  output logic [N-1:0]   full_miso,
  aes_spi_ctrl_if.master core
);

  import aes_pkg::*;

  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int PADW = N - BLK_W - 8;

  ctrl_state_t      state_q, state_d;
  logic             spi_done_q;
  logic             rise;
  logic [TW-1:0]    timer_q, timer_d;
  logic             timer_hit;
  logic [KEY_W-1:0] key_q, key_d;
  logic [BLK_W-1:0] pt_q, pt_d;
  logic [BLK_W-1:0] result_q, result_d;
  status_t          stat_q, stat_d;
  logic [N-1:0]     miso_q, miso_d;
  logic [7:0]       status_byte;

  assign rise      = spi_done & ~spi_done_q;
  assign timer_hit = (timer_q == TW'(TIMEOUT - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      spi_done_q <= 1'b1;
      timer_q    <= '0;
      key_q      <= '0;
      pt_q       <= '0;
      result_q   <= '0;
      stat_q     <= '0;
      miso_q     <= '0;
    end else begin
      state_q    <= state_d;
      spi_done_q <= spi_done;
      timer_q    <= timer_d;
      key_q      <= key_d;
      pt_q       <= pt_d;
      result_q   <= result_d;
      stat_q     <= stat_d;
      miso_q     <= miso_d;
    end
  end

  // Next-state decision
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rise) state_d = SETTLE;
      SETTLE:  state_d = START;
      START:   state_d = RUN;
      RUN:     if (core.core_done || timer_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath next values; completion beats timeout in RUN
  always_comb begin
    key_d    = key_q;
    pt_d     = pt_q;
    result_d = result_q;
    stat_d   = stat_q;
    timer_d  = timer_q;
    unique case (state_q)
      SETTLE: begin
        key_d          = full_mosi[N-1:BLK_W];
        pt_d           = full_mosi[BLK_W-1:0];
        stat_d.valid   = 1'b0;
        stat_d.timeout = 1'b0;
        stat_d.overrun = 1'b0;
      end
      START: timer_d = '0;
      RUN: begin
        if (timer_q != '1) timer_d = timer_q + TW'(1);
        if (core.core_done) begin
          result_d     = core.core_ct;
          stat_d.valid = 1'b1;
          stat_d.seq   = stat_q.seq + 4'd1;
        end else if (timer_hit) begin
          stat_d.timeout = 1'b1;
          stat_d.valid   = 1'b0;
        end
      end
      default: ;
    endcase
    // A transaction ending mid-op is dropped but remembered; set wins over the SETTLE clear
    if (rise && (state_q != IDLE)) stat_d.overrun = 1'b1;
    stat_d.busy = (state_d != IDLE);

    status_byte                       = '0;
    status_byte[STAT_VALID]           = stat_q.valid;
    status_byte[STAT_TIMEOUT]         = stat_q.timeout;
    status_byte[STAT_OVERRUN]         = stat_q.overrun;
    status_byte[STAT_BUSY]            = stat_q.busy;
    status_byte[STAT_SEQ_LSB +: 4]    = stat_q.seq;

    // Only refresh the shift word while the slave is idle
    miso_d = spi_done ? {result_q, {PADW{1'b0}}, status_byte} : miso_q;

    core.core_start = (state_q == START);
  end

  assign core.core_key = key_q;
  assign core.core_pt  = pt_q;
  assign full_miso     = miso_q;

endmodule

// File: tb/tb_aes_spi_ctrl.sv
`timescale 1ns/1ps
module tb_aes_spi_ctrl;

  localparam int KW = 128;
  localparam int BW = 128;
  localparam int NW = KW + BW;
  localparam int TO = 64;

  localparam logic [KW-1:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [BW-1:0] PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [BW-1:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          spi_done = 1'b1;
  logic [NW-1:0] full_mosi = '0;
  logic [NW-1:0] full_miso;

  aes_spi_ctrl_if #(.KEY_W(KW), .BLK_W(BW)) core_if ();

  aes_spi_ctrl #(.KEY_W(KW), .BLK_W(BW), .N(NW), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .spi_done (spi_done),
    .full_mosi(full_mosi),
    .full_miso(full_miso),
    .core     (core_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- AES core stand-in ----------------
  int            core_delay = 5;   // <= 0 means the core never answers
  int            resp_cnt   = 0;
  logic [BW-1:0] next_ct    = '0;
  logic [BW-1:0] resp_ct    = '0;

  initial begin
    core_if.core_done = 1'b0;
    core_if.core_ct   = '0;
    forever begin
      @(negedge clk);
      core_if.core_done = 1'b0;
      if (core_if.core_start === 1'b1) begin
        resp_cnt = core_delay;
        resp_ct  = next_ct;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          core_if.core_done = 1'b1;
          core_if.core_ct   = resp_ct;
        end
      end
    end
  end

  // ---------------- behavioural model ----------------
  // m_age: 0 = no op; otherwise clock edges since the transaction-ending rise.
  // Edge 1 latches data, edge 2 launches, RUN cycle index = m_age - 3.
  logic          m_prev  = 1'b1;
  int            m_age   = 0;
  logic [KW-1:0] m_key   = '0;
  logic [BW-1:0] m_pt    = '0;
  logic [BW-1:0] m_res   = '0;
  logic          m_valid = 1'b0;
  logic          m_to    = 1'b0;
  logic          m_ovr   = 1'b0;
  int            m_seq   = 0;
  logic [NW-1:0] m_miso  = '0;
  logic          m_start = 1'b0;

  task automatic model_step();
    logic r;
    logic [7:0] st;
    if (reset) begin
      m_prev = 1'b1; m_age = 0; m_key = '0; m_pt = '0; m_res = '0;
      m_valid = 1'b0; m_to = 1'b0; m_ovr = 1'b0; m_seq = 0; m_miso = '0;
    end else begin
      r  = spi_done && !m_prev;
      st = {4'(m_seq), (m_age > 0), m_ovr, m_to, m_valid};
      if (spi_done) m_miso = {m_res, 120'b0, st};
      m_prev = spi_done;
      if (m_age == 0) begin
        if (r) m_age = 1;
      end else if (m_age == 1) begin
        m_key = full_mosi[NW-1:BW];
        m_pt  = full_mosi[BW-1:0];
        m_valid = 1'b0; m_to = 1'b0; m_ovr = r;
        m_age = 2;
      end else if (m_age == 2) begin
        m_ovr = m_ovr | r;
        m_age = 3;
      end else begin
        m_ovr = m_ovr | r;
        if (core_if.core_done) begin
          m_res = core_if.core_ct; m_valid = 1'b1; m_seq = (m_seq + 1) % 16;
          m_age = 0;
        end else if (m_age - 3 == TO - 1) begin
          m_to = 1'b1; m_valid = 1'b0;
          m_age = 0;
        end else begin
          m_age++;
        end
      end
    end
    m_start = (m_age == 2);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("miso",  full_miso, m_miso);
      check("start", NW'(core_if.core_start), NW'(m_start));
      check("key",   NW'(core_if.core_key), NW'(m_key));
      check("pt",    NW'(core_if.core_pt), NW'(m_pt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic txn(input logic [KW-1:0] k, input logic [BW-1:0] p, input int low);
    @(negedge clk);
    full_mosi = {k, p};
    spi_done  = 1'b0;
    repeat (low) @(negedge clk);
    spi_done = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (m_age != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (m_age != 0) begin
      bad++;
      $display("FAIL wait_idle: op still active after %0d cycles", budget);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [NW-1:0] m0;
  logic          changed;
  int            k;

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;

    // Timeout from reset: result stays zero, status 0x02, exact duration
    core_delay = 0;
    txn(rnd128(), rnd128(), 2);
    k = 0;
    while (core_if.core_start !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    check("to_launch", NW'(core_if.core_start), NW'(1));
    k = 0;
    do begin @(negedge clk); k++; end while (full_miso[3] !== 1'b0 && k < 200);
    check("to_latency", NW'(k), NW'(66));
    @(negedge clk);
    check("to_status", full_miso, {128'b0, 120'b0, 8'h02});

    // Basic op with known vectors
    do_reset();
    core_delay = 10; next_ct = CT0;
    txn(KEY0, PT0, 3);
    @(negedge clk); check("lat_settle", NW'(core_if.core_start), NW'(0));
    @(negedge clk); check("lat_start",  NW'(core_if.core_start), NW'(1));
    check("basic_key", NW'(core_if.core_key), NW'(KEY0));
    check("basic_pt",  NW'(core_if.core_pt),  NW'(PT0));
    wait_idle(200);
    repeat (2) @(negedge clk);
    check("basic_miso", full_miso, {CT0, 120'b0, 8'h11});

    // Timeout after a completed op keeps the old result
    core_delay = 0;
    txn(rnd128(), rnd128(), 2);
    wait_idle(200);
    repeat (2) @(negedge clk);
    check("to_keep", full_miso, {CT0, 120'b0, 8'h12});

    // Overrun: second transaction ends while RUN
    do_reset();
    core_delay = 30; next_ct = CT0;
    txn(KEY0, PT0, 2);
    repeat (5) @(negedge clk);
    txn(~KEY0, ~PT0, 3);
    wait_idle(200);
    repeat (2) @(negedge clk);
    check("ovr_status", full_miso, {CT0, 120'b0, 8'h15});
    check("ovr_key", NW'(core_if.core_key), NW'(KEY0));

    // Publication freeze while a transaction is in progress
    do_reset();
    core_delay = 20; next_ct = ~CT0;
    txn(KEY0, PT0, 2);
    repeat (5) @(negedge clk);
    full_mosi = {rnd128(), rnd128()};
    spi_done  = 1'b0;
    @(negedge clk);
    m0 = full_miso;
    changed = 1'b0;
    repeat (39) begin
      @(negedge clk);
      if (full_miso !== m0) changed = 1'b1;
    end
    check("freeze_hold", NW'(changed), NW'(0));
    spi_done = 1'b1;
    @(negedge clk);
    check("freeze_update", full_miso, {~CT0, 120'b0, 8'h11});
    wait_idle(200);

    // Sequence counter wraps after 16 completions
    do_reset();
    core_delay = 3;
    for (int i = 0; i < 17; i++) begin
      next_ct = rnd128();
      txn(rnd128(), rnd128(), $urandom_range(1, 4));
      wait_idle(200);
      repeat (2) @(negedge clk);
      check("wrap_valid", NW'(full_miso[0]), NW'(1));
      check("wrap_result", NW'(full_miso[NW-1:NW-BW]), NW'(next_ct));
    end
    check("wrap_seq", NW'(full_miso[7:4]), NW'(1));

    // Reset in RUN; the late core_done must be ignored
    do_reset();
    core_delay = 15; next_ct = CT0;
    txn(KEY0, PT0, 2);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_miso",  full_miso, '0);
    check("rst_key",   NW'(core_if.core_key), '0);
    check("rst_pt",    NW'(core_if.core_pt), '0);
    check("rst_start", NW'(core_if.core_start), '0);
    core_delay = 4; next_ct = ~CT0;
    txn(~KEY0, ~PT0, 2);
    wait_idle(200);
    repeat (2) @(negedge clk);
    check("rst_next", full_miso, {~CT0, 120'b0, 8'h11});

    // Randomized traffic: overlaps, timeouts, late answers, stray resets
    do_reset();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       core_delay = 0;
        1:       core_delay = $urandom_range(60, 80);
        default: core_delay = $urandom_range(1, 25);
      endcase
      next_ct = rnd128();
      txn(rnd128(), rnd128(), $urandom_range(1, 6));
      repeat ($urandom_range(0, 70)) @(negedge clk);
      if ($urandom_range(0, 19) == 0) do_reset();
    end
    wait_idle(200);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
